ipsxb_uart_rd_sched: RTL and testbench

//  Read scheduler behind the UART 32-bit control block's read port.

---
 rtl/ipsxb_uart_rd_sched.sv | 105 ++++++++++
 tb/tb_ipsxb_uart_rd_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxb_uart_rd_sched.sv
// ipsxb_uart_rd_sched: one-at-a-time read scheduler fanning UART reads out to 4 status slaves with timeout
module ipsxb_uart_rd_sched #(
  parameter logic [15:0] TIMEOUT  = 16'd255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter logic [3:0]  SLV_EN   = 4'b1111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read_req,
  input  logic [8:0]   uart_rd_addr,
  output logic         read_ack,
  output logic [31:0]  status_bus,
  output logic [3:0]   slv_req,
  output logic [6:0]   slv_addr,
  input  logic [3:0]   slv_ack,
  input  logic [127:0] slv_data,
  output logic         timeout_p,
  output logic [7:0]   err_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] req_q, req_d;
  logic [6:0] addr_q, addr_d;
  logic [31:0] status_q, status_d;
  logic ack_q, ack_d;
  logic to_q, to_d;
  logic [7:0] err_q, err_d;
  assign read_ack = ack_q;
  assign status_bus = status_q;
  assign slv_req = req_q;
  assign slv_addr = addr_q;
  assign timeout_p = to_q;
  assign err_cnt = err_q;
  // next-state and registered-output decode; read_ack/timeout_p are set on the edge entering RESP
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    req_d = req_q;
    addr_d = addr_q;
    status_d = status_q;
    ack_d = 1'b0;
    to_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE: if (read_req) begin
        sel_d = uart_rd_addr[8:7];
        addr_d = uart_rd_addr[6:0];
        cnt_d = '0;
        if (SLV_EN[uart_rd_addr[8:7]]) begin
          req_d = 4'b0001 << uart_rd_addr[8:7];
          state_d = WAIT;
        end else begin
          status_d = ERR_DATA;
          ack_d = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: if (slv_ack[sel_q]) begin
        status_d = slv_data[{sel_q, 5'd0} +: 32];
        req_d = '0;
        ack_d = 1'b1;
        state_d = RESP;
      end else if (cnt_q == TIMEOUT - 16'd1) begin
        status_d = ERR_DATA;
        req_d = '0;
        ack_d = 1'b1;
        to_d = 1'b1;
        err_d = err_q + {7'd0, ~&err_q};
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      RESP: state_d = DONE;
      DONE: state_d = read_req ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      req_q <= '0;
      addr_q <= '0;
      status_q <= '0;
      ack_q <= 1'b0;
      to_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      addr_q <= addr_d;
      status_q <= status_d;
      ack_q <= ack_d;
      to_q <= to_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ipsxb_uart_rd_sched.sv
// tb_ipsxb_uart_rd_sched: scoreboard bench for the UART read scheduler
module tb_ipsxb_uart_rd_sched;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic read_req = 1'b0;
  logic [8:0] uart_rd_addr = '0;
  logic read_ack;
  logic [31:0] status_bus;
  logic [3:0] slv_req;
  logic [6:0] slv_addr;
  logic [3:0] slv_ack = '0;
  logic [127:0] slv_data = '0;
  logic timeout_p;
  logic [7:0] err_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_err = '0;
  typedef struct {logic [31:0] data; int lat; int to;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ipsxb_uart_rd_sched #(.TIMEOUT(16'd8), .ERR_DATA(ERR), .SLV_EN(4'b1011)) dut (
    .clk(clk), .rst(rst), .read_req(read_req), .uart_rd_addr(uart_rd_addr),
    .read_ack(read_ack), .status_bus(status_bus), .slv_req(slv_req), .slv_addr(slv_addr),
    .slv_ack(slv_ack), .slv_data(slv_data), .timeout_p(timeout_p), .err_cnt(err_cnt)
  );

  // read_req asserted in cycle 1; lat is the cycle index in which read_ack is seen
  task automatic run_read(input logic [8:0] addr, input int dly, input logic [31:0] data,
                          input logic [3:0] spur, input int hold,
                          output int lat, output logic [31:0] rd, output int n_to, output int n_ack,
                          output logic [3:0] req_seen, output logic [6:0] addr_seen);
    int cyc;
    int rc;
    bit done;
    lat = -1; rd = '0; n_to = 0; n_ack = 0; req_seen = '0; addr_seen = '0; rc = -1; done = 0;
    slv_data = {32'hBAD3_3333, 32'hBAD2_2222, 32'hBAD1_1111, 32'hBAD0_0000};
    slv_data[32*addr[8:7] +: 32] = data;
    @(posedge clk); #1;
    read_req = 1'b1; uart_rd_addr = addr; cyc = 1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (slv_req != 0 && rc < 0) begin rc = cyc; req_seen = slv_req; addr_seen = slv_addr; end
      slv_ack = (rc >= 0 && dly >= 0 && cyc - rc == dly) ? slv_req : 4'b0;
      if (slv_req != 0 && cyc % 2 == 1) slv_ack = slv_ack | spur;
      if (timeout_p) n_to++;
      if (read_ack) begin
        n_ack++;
        if (lat < 0) begin lat = cyc; rd = status_bus; end
      end
      if (lat >= 0 && cyc >= lat + hold) done = 1;
    end
    read_req = 1'b0; slv_ack = '0;
    repeat (3) begin
      @(posedge clk); #1;
      if (read_ack) n_ack++;
      if (timeout_p) n_to++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (read_ack !== 1'b0) begin n_bad++; $display("FAIL rst_read_ack got %b want 0", read_ack); end
    n_cmp++; if (status_bus !== 32'h0) begin n_bad++; $display("FAIL rst_status got %h want 0", status_bus); end
    n_cmp++; if (slv_req !== 4'h0) begin n_bad++; $display("FAIL rst_slv_req got %b want 0000", slv_req); end
    n_cmp++; if (slv_addr !== 7'h0) begin n_bad++; $display("FAIL rst_slv_addr got %h want 0", slv_addr); end
    n_cmp++; if (timeout_p !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_p got %b want 0", timeout_p); end
    n_cmp++; if (err_cnt !== 8'h0) begin n_bad++; $display("FAIL rst_err_cnt got %h want 0", err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_enabled_read;
    exp_t e;
    int lat, n_to, n_ack;
    logic [31:0] rd;
    logic [3:0] rq;
    logic [6:0] ra;
    sb.push_back('{32'h1234_5678, 7, 0});
    run_read(9'h085, 4, 32'h1234_5678, 4'b0, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    n_cmp++; if (rq !== 4'b0010) begin n_bad++; $display("FAIL en_slv_req got %b want 0010", rq); end
    n_cmp++; if (ra !== 7'h05) begin n_bad++; $display("FAIL en_slv_addr got %h want 05", ra); end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL en_latency got %0d want %0d", lat, e.lat); end
    n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL en_data got %h want %h", rd, e.data); end
    n_cmp++; if (n_to !== e.to || n_ack !== 1) begin n_bad++; $display("FAIL en_pulses got to=%0d ack=%0d want to=%0d ack=1", n_to, n_ack, e.to); end
    sb.push_back('{32'hA5A5_0F0F, 3, 0});
    run_read(9'h07F, 0, 32'hA5A5_0F0F, 4'b0, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    n_cmp++; if (rq !== 4'b0001 || ra !== 7'h7F) begin n_bad++; $display("FAIL min_sel got req=%b addr=%h want 0001/7f", rq, ra); end
    n_cmp++; if (lat !== e.lat || rd !== e.data) begin n_bad++; $display("FAIL min_read got lat=%0d data=%h want %0d/%h", lat, rd, e.lat, e.data); end
    sb.push_back('{32'h0BAD_F00D, 5, 0});
    run_read(9'h1FF, 2, 32'h0BAD_F00D, 4'b0, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    n_cmp++; if (rq !== 4'b1000 || lat !== e.lat || rd !== e.data) begin n_bad++; $display("FAIL s3_read got req=%b lat=%0d data=%h want 1000/%0d/%h", rq, lat, rd, e.lat, e.data); end
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL en_err_cnt got %h want %h", err_cnt, exp_err); end
  endtask

  task automatic test_timeout;
    exp_t e;
    int lat, n_to, n_ack;
    logic [31:0] rd;
    logic [3:0] rq;
    logic [6:0] ra;
    sb.push_back('{ERR, 10, 1});
    run_read(9'h180, -1, 32'h5555_AAAA, 4'b0, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    exp_err = exp_err + 8'd1;
    n_cmp++; if (rq !== 4'b1000) begin n_bad++; $display("FAIL to_slv_req got %b want 1000", rq); end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL to_latency got %0d want %0d", lat, e.lat); end
    n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL to_data got %h want %h", rd, e.data); end
    n_cmp++; if (n_to !== e.to) begin n_bad++; $display("FAIL to_pulse got %0d want %0d", n_to, e.to); end
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL to_err_cnt got %h want %h", err_cnt, exp_err); end
  endtask

  task automatic test_disabled;
    exp_t e;
    int lat, n_to, n_ack;
    logic [31:0] rd;
    logic [3:0] rq;
    logic [6:0] ra;
    sb.push_back('{ERR, 2, 0});
    run_read(9'h100, 0, 32'h7777_7777, 4'b0, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    n_cmp++; if (rq !== 4'b0000) begin n_bad++; $display("FAIL dis_slv_req got %b want 0000", rq); end
    n_cmp++; if (lat !== e.lat || rd !== e.data) begin n_bad++; $display("FAIL dis_read got lat=%0d data=%h want %0d/%h", lat, rd, e.lat, e.data); end
    n_cmp++; if (n_to !== 0 || err_cnt !== exp_err) begin n_bad++; $display("FAIL dis_err got to=%0d err=%h want 0/%h", n_to, err_cnt, exp_err); end
  endtask

  task automatic test_ack_at_timeout;
    exp_t e;
    int lat, n_to, n_ack;
    logic [31:0] rd;
    logic [3:0] rq;
    logic [6:0] ra;
    sb.push_back('{32'hCAFE_F00D, 10, 0});
    run_read(9'h000, 7, 32'hCAFE_F00D, 4'b0100, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat || rd !== e.data) begin n_bad++; $display("FAIL edge_ack got lat=%0d data=%h want %0d/%h", lat, rd, e.lat, e.data); end
    n_cmp++; if (n_to !== e.to || err_cnt !== exp_err) begin n_bad++; $display("FAIL edge_ack_to got to=%0d err=%h want %0d/%h", n_to, err_cnt, e.to, exp_err); end
    sb.push_back('{ERR, 10, 1});
    run_read(9'h000, 8, 32'hCAFE_F00D, 4'b0100, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    exp_err = exp_err + 8'd1;
    n_cmp++; if (lat !== e.lat || rd !== e.data || n_to !== e.to) begin n_bad++; $display("FAIL late_ack got lat=%0d data=%h to=%0d want %0d/%h/%0d", lat, rd, n_to, e.lat, e.data, e.to); end
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL late_ack_err got %h want %h", err_cnt, exp_err); end
  endtask

  task automatic test_saturation;
    int lat, n_to, n_ack, bad_lat;
    logic [31:0] rd;
    logic [3:0] rq;
    logic [6:0] ra;
    bad_lat = 0;
    for (int i = 0; i < 257; i++) begin
      run_read(9'h180, -1, 32'h0, 4'b0, 0, lat, rd, n_to, n_ack, rq, ra);
      if (lat != 10 || rd != ERR) bad_lat++;
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      if (i == 250) begin
        n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL sat_mid got %h want %h", err_cnt, exp_err); end
      end
    end
    n_cmp++; if (bad_lat !== 0) begin n_bad++; $display("FAIL sat_reads got %0d bad want 0", bad_lat); end
    n_cmp++; if (err_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_err_cnt got %h want ff", err_cnt); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat, n_to, n_ack;
    logic [31:0] rd;
    logic [3:0] rq;
    logic [6:0] ra;
    sb.push_back('{32'h600D_0001, 4, 0});
    run_read(9'h0A3, 1, 32'h600D_0001, 4'b0, 3, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    n_cmp++; if (n_ack !== 1) begin n_bad++; $display("FAIL held_req acks got %0d want 1", n_ack); end
    n_cmp++; if (lat !== e.lat || rd !== e.data || ra !== 7'h23) begin n_bad++; $display("FAIL held_read got lat=%0d data=%h addr=%h want %0d/%h/23", lat, rd, ra, e.lat, e.data); end
    sb.push_back('{32'h600D_0002, 4, 0});
    run_read(9'h0A4, 1, 32'h600D_0002, 4'b0, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat || rd !== e.data || n_ack !== 1) begin n_bad++; $display("FAIL b2b_read got lat=%0d data=%h ack=%0d want %0d/%h/1", lat, rd, n_ack, e.lat, e.data); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int lat, n_to, n_ack, acks;
    logic [31:0] rd;
    logic [3:0] rq;
    logic [6:0] ra;
    @(posedge clk); #1;
    read_req = 1'b1; uart_rd_addr = 9'h180;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (slv_req !== 4'b1000) begin n_bad++; $display("FAIL mid_wait_req got %b want 1000", slv_req); end
    rst = 1'b1; read_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (slv_req !== 4'b0000 || read_ack !== 1'b0) begin n_bad++; $display("FAIL mid_rst got req=%b ack=%b want 0000/0", slv_req, read_ack); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL mid_rst_err got %h want 00", err_cnt); end
    rst = 1'b0;
    exp_err = '0;
    acks = 0;
    repeat (12) begin @(posedge clk); #1; if (read_ack || timeout_p) acks++; end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL mid_rst_quiet got %0d pulses want 0", acks); end
    sb.push_back('{32'h0DDB_A115, 4, 0});
    run_read(9'h081, 1, 32'h0DDB_A115, 4'b0, 0, lat, rd, n_to, n_ack, rq, ra);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat || rd !== e.data || rq !== 4'b0010) begin n_bad++; $display("FAIL post_rst_read got lat=%0d data=%h req=%b want %0d/%h/0010", lat, rd, rq, e.lat, e.data); end
  endtask

  initial begin
    test_reset;
    test_enabled_read;
    test_timeout;
    test_disabled;
    test_ack_at_timeout;
    test_saturation;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
